// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx serializer between N_REQ byte requesters,
// with TX_DONE rising-edge detection and a watchdog that aborts a stuck grant.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 20000,
    parameter int TO_W    = 15
) (
    input  logic                       CLK,
    input  logic                       ARST,
    input  logic [N_REQ-1:0]           REQ,
    input  logic [N_REQ*DW-1:0]        REQ_DIN,
    output logic [N_REQ-1:0]           REQ_ACK,
    output logic [N_REQ-1:0]           REQ_DONE,
    output logic [N_REQ-1:0]           REQ_ERR,
    output logic                       TX_ENA,
    output logic [DW-1:0]              TX_DIN,
    input  logic                       TX_DONE,
    output logic                       BUSY,
    output logic [$clog2(N_REQ)-1:0]   GRANT_ID
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, gid_q, gid_d, win, idx, nxt;
    logic [DW-1:0]    din_q, din_d;
    logic [N_REQ-1:0] ack_q, ack_d, done_q, done_d, err_q, err_d;
    logic             ena_q, ena_d, txd_q, rise, cool;
    logic [TO_W-1:0]  cnt_q, cnt_d;

    // Lowest offset from ptr wins, so scan from the far end and let nearer hits overwrite.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr_q) + i) % N_REQ);
            if (REQ[idx]) win = idx;
        end
    end

    assign rise = TX_DONE & ~txd_q;
    assign nxt  = IW'((int'(gid_q) + 1) % N_REQ);
    // The completion/abort pulse cycle never grants, guaranteeing an idle gap between frames.
    assign cool = |done_q | |err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;
        ena_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (|REQ && !cool) begin
                din_d   = REQ_DIN[win*DW +: DW];
                gid_d   = win;
                ack_d   = N_REQ'(1) << win;
                ena_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
        end else begin
            cnt_d = cnt_q + TO_W'(1);
            if (rise) begin
                done_d  = N_REQ'(1) << gid_q;
                ptr_d   = nxt;
                state_d = S_IDLE;
            end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                err_d   = N_REQ'(1) << gid_q;
                ptr_d   = nxt;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            ena_q   <= 1'b0;
            txd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ena_q   <= ena_d;
            txd_q   <= TX_DONE;
        end
    end

    assign REQ_ACK  = ack_q;
    assign REQ_DONE = done_q;
    assign REQ_ERR  = err_q;
    assign TX_ENA   = ena_q;
    assign TX_DIN   = din_q;
    assign BUSY     = state_q == S_WAIT;
    assign GRANT_ID = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and directed checks of the round-robin uart_tx arbiter
// with a shortened watchdog (TIMEOUT=50).
module tb_uart_tx_arbiter;
    logic        CLK = 1'b0;
    logic        ARST = 1'b1;
    logic [3:0]  REQ = '0;
    logic [31:0] REQ_DIN = '0;
    logic        TX_DONE = 1'b0;
    logic [3:0]  REQ_ACK, REQ_DONE, REQ_ERR;
    logic        TX_ENA, BUSY;
    logic [7:0]  TX_DIN;
    logic [1:0]  GRANT_ID;

    int total = 0;
    int passes = 0;

    uart_tx_arbiter #(.N_REQ(4), .DW(8), .TIMEOUT(50), .TO_W(15)) dut (
        .CLK(CLK), .ARST(ARST), .REQ(REQ), .REQ_DIN(REQ_DIN),
        .REQ_ACK(REQ_ACK), .REQ_DONE(REQ_DONE), .REQ_ERR(REQ_ERR),
        .TX_ENA(TX_ENA), .TX_DIN(TX_DIN), .TX_DONE(TX_DONE),
        .BUSY(BUSY), .GRANT_ID(GRANT_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] din;
        logic        txd;
        logic [3:0]  ack, done, err;
        logic        ena, busy;
        logic [1:0]  gid;
        logic [7:0]  tdin;
    } vec_t;

    vec_t v[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [23:0] outs();
        return {REQ_ACK, REQ_DONE, REQ_ERR, TX_ENA, BUSY, GRANT_ID, TX_DIN};
    endfunction

    task automatic do_reset();
        ARST = 1'b1;
        REQ = '0;
        TX_DONE = 1'b0;
        @(negedge CLK);
        ARST = 1'b0;
    endtask

    task automatic serve(input string name, input logic [1:0] id, input logic [7:0] b);
        int n = 0;
        while (!TX_ENA && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_ena"}, 64'(TX_ENA), 64'd1);
        check({name, "_grant"}, {REQ_ACK, GRANT_ID, TX_DIN}, {4'b0001 << id, id, b});
        TX_DONE = 1'b1;
        @(negedge CLK);
        check({name, "_done"}, 64'(REQ_DONE), 64'(4'b0001 << id));
        TX_DONE = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int n;
        int err_at;
        logic saw_done;
        localparam logic [31:0] D1 = 32'h00AB0000;
        localparam logic [31:0] D4 = 32'h13121110;
        // rst req din txd | ack done err ena busy gid tdin
        v.push_back('{1'b1, 4'b0000, D1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
        v.push_back('{1'b0, 4'b0100, D1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 8'hAB});
        v.push_back('{1'b0, 4'b0000, D1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hAB});
        v.push_back('{1'b0, 4'b0000, D1, 1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hAB});
        v.push_back('{1'b0, 4'b0000, D1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hAB});
        v.push_back('{1'b1, 4'b0000, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
        v.push_back('{1'b0, 4'b1111, D4, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h10});
        v.push_back('{1'b0, 4'b1110, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h10});
        v.push_back('{1'b0, 4'b1110, D4, 1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h10});
        v.push_back('{1'b0, 4'b1110, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h10});
        v.push_back('{1'b0, 4'b1110, D4, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h11});
        v.push_back('{1'b0, 4'b1100, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h11});
        v.push_back('{1'b0, 4'b1100, D4, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h11});
        v.push_back('{1'b0, 4'b1100, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h11});
        v.push_back('{1'b0, 4'b1100, D4, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h12});
        v.push_back('{1'b0, 4'b1000, D4, 1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h12});
        v.push_back('{1'b0, 4'b1000, D4, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h12});
        v.push_back('{1'b0, 4'b1000, D4, 1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h13});
        v.push_back('{1'b0, 4'b0000, D4, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h13});
        v.push_back('{1'b0, 4'b0000, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h13});
        v.push_back('{1'b0, 4'b0000, D4, 1'b1, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h13});
        v.push_back('{1'b0, 4'b0000, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h13});
        v.push_back('{1'b0, 4'b0000, D4, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h13});
        v.push_back('{1'b0, 4'b0000, D4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h13});

        @(negedge CLK);
        foreach (v[i]) begin
            if (v[i].rst) ARST = 1'b1;
            REQ = v[i].req;
            REQ_DIN = v[i].din;
            TX_DONE = v[i].txd;
            @(negedge CLK);
            ARST = 1'b0;
            check($sformatf("row%0d", i), outs(),
                  {v[i].ack, v[i].done, v[i].err, v[i].ena, v[i].busy, v[i].gid, v[i].tdin});
        end

        // Fairness: requester 0 held permanently alongside requester 2.
        do_reset();
        REQ = 4'b0101;
        REQ_DIN = D4;
        serve("fair0", 2'd0, 8'h10);
        serve("fair1", 2'd2, 8'h12);
        serve("fair2", 2'd0, 8'h10);
        serve("fair3", 2'd2, 8'h12);
        REQ = '0;
        @(negedge CLK);
        @(negedge CLK);

        // Watchdog: TX_DONE never arrives for requester 1.
        do_reset();
        REQ = 4'b0010;
        REQ_DIN = 32'h00005500;
        @(negedge CLK);
        check("wd_grant", {REQ_ACK, TX_ENA, GRANT_ID, TX_DIN}, {4'b0010, 1'b1, 2'd1, 8'h55});
        REQ = 4'b1011;
        err_at = -1;
        saw_done = 1'b0;
        n = 0;
        while (err_at < 0 && n < 60) begin
            @(negedge CLK);
            n++;
            if (|REQ_DONE) saw_done = 1'b1;
            if (|REQ_ERR) begin
                err_at = n;
                check("wd_err_bits", 64'(REQ_ERR), 64'(4'b0010));
            end
        end
        check("wd_err_delay", 64'(err_at), 64'd50);
        check("wd_no_done", 64'(saw_done), 64'd0);
        serve("wd_next", 2'd3, 8'h00);
        REQ = '0;

        // Reset mid-frame clears outputs before the next clock edge.
        do_reset();
        REQ = 4'b0100;
        REQ_DIN = 32'h77AB0000;
        @(negedge CLK);
        REQ = '0;
        @(negedge CLK);
        check("mid_busy", 64'(BUSY), 64'd1);
        ARST = 1'b1;
        #1;
        check("mid_async", outs(), 24'h0);
        @(negedge CLK);
        ARST = 1'b0;
        REQ = 4'b1000;
        serve("mid_after", 2'd3, 8'h77);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
